// File: rtl/p22_row_feeder.sv
// p22_row_feeder: one-entry buffer between the ray tracer and the row renderer.
// A traced row result is parked in a pending register and promoted to the
// active set on row_start. A restoring divider then derives the fixed-point
// texv step for the active wall height. An accumulator advances by that step
// on every visible pixel.
//
// state   | meaning
// S_IDLE  | step is valid; pix_adv advances the texv accumulator
// S_DIV   | divider running (busy); pix_adv is ignored and flagged late
module p22_row_feeder #(
    parameter int H_VIEW = 640,
    parameter int FRAC   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_wall,
    input  logic        wr_side,
    input  logic [10:0] wr_size,
    input  logic [5:0]  wr_texu,
    input  logic        row_start,
    input  logic        pix_adv,
    output logic [1:0]  wall,
    output logic        side,
    output logic [10:0] size,
    output logic [5:0]  texu,
    output logic [5:0]  texv,
    output logic        busy,
    output logic        underrun,
    output logic        late
);
    localparam int AW        = 6 + FRAC;
    localparam int HALF_SIZE = H_VIEW / 2;
    localparam int CW        = $clog2(AW);

    // 2^(5+FRAC) is exactly the MSB of the AW-bit accumulator.
    localparam logic [AW-1:0] DIVIDEND = {1'b1, {(AW-1){1'b0}}};
    localparam logic [AW-1:0] HALF_C   = AW'(HALF_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(AW - 1);

    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [10:0]    rem_q, rem_d;
    logic [AW-1:0]  quo_q, quo_d;
    logic [AW-1:0]  step_q, step_d;
    logic [AW-1:0]  acc_q, acc_d;

    logic           pend_full_q, pend_full_d;
    logic [1:0]     pend_wall_q, pend_wall_d;
    logic           pend_side_q, pend_side_d;
    logic [10:0]    pend_size_q, pend_size_d;
    logic [5:0]     pend_texu_q, pend_texu_d;

    logic [1:0]     wall_q, wall_d;
    logic           side_q, side_d;
    logic [10:0]    size_q, size_d;
    logic [5:0]     texu_q, texu_d;
    logic           underrun_q, underrun_d;
    logic           late_q, late_d;

    logic           wr_fire;
    logic [11:0]    rem_sh;
    logic [10:0]    rem_sub;
    logic           q_bit;
    logic [AW-1:0]  quo_nx;
    logic [AW-1:0]  v0;

    // The pending slot frees up in the same cycle it is promoted.
    assign wr_ready = ~pend_full_q | row_start;
    assign wr_fire  = wr_valid & wr_ready;

    // One restoring-division step, MSB first; divisor 0 yields all-ones.
    always_comb begin
        rem_sh  = {rem_q, DIVIDEND[cnt_q]};
        rem_sub = rem_sh[10:0] - size_q;
        q_bit   = (rem_sh >= {1'b0, size_q});
        quo_nx  = {quo_q[AW-2:0], q_bit};
        v0      = DIVIDEND - HALF_C * quo_nx;
    end

    // Next-state logic: pending buffer, row promotion, divider FSM and accumulator.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        step_d      = step_q;
        acc_d       = acc_q;
        pend_wall_d = pend_wall_q;
        pend_side_d = pend_side_q;
        pend_size_d = pend_size_q;
        pend_texu_d = pend_texu_q;
        wall_d      = wall_q;
        side_d      = side_q;
        size_d      = size_q;
        texu_d      = texu_q;
        underrun_d  = underrun_q;
        late_d      = late_q;

        pend_full_d = wr_fire | (pend_full_q & ~row_start);
        if (wr_fire) begin
            pend_wall_d = wr_wall;
            pend_side_d = wr_side;
            pend_size_d = wr_size;
            pend_texu_d = wr_texu;
        end

        if (row_start) begin
            // A new row always restarts the divider, even mid-division.
            state_d = S_DIV;
            cnt_d   = CNT_LAST;
            rem_d   = '0;
            quo_d   = '0;
            acc_d   = '0;
            late_d  = 1'b0;
            if (pend_full_q) begin
                wall_d     = pend_wall_q;
                side_d     = pend_side_q;
                size_d     = pend_size_q;
                texu_d     = pend_texu_q;
                underrun_d = 1'b0;
            end else begin
                size_d     = '0;
                underrun_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pix_adv) begin
                        acc_d = acc_q + step_q;
                    end
                end
                S_DIV: begin
                    if (pix_adv) begin
                        late_d = 1'b1;
                    end
                    rem_d = q_bit ? rem_sub : rem_sh[10:0];
                    quo_d = quo_nx;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        step_d  = quo_nx;
                        acc_d   = v0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            pend_full_q <= 1'b0;
            pend_wall_q <= '0;
            pend_side_q <= 1'b0;
            pend_size_q <= '0;
            pend_texu_q <= '0;
            wall_q      <= '0;
            side_q      <= 1'b0;
            size_q      <= '0;
            texu_q      <= '0;
            underrun_q  <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            pend_full_q <= pend_full_d;
            pend_wall_q <= pend_wall_d;
            pend_side_q <= pend_side_d;
            pend_size_q <= pend_size_d;
            pend_texu_q <= pend_texu_d;
            wall_q      <= wall_d;
            side_q      <= side_d;
            size_q      <= size_d;
            texu_q      <= texu_d;
            underrun_q  <= underrun_d;
            late_q      <= late_d;
        end
    end

    assign wall     = wall_q;
    assign side     = side_q;
    assign size     = size_q;
    assign texu     = texu_q;
    assign texv     = acc_q[AW-1:FRAC];
    assign busy     = (state_q == S_DIV);
    assign underrun = underrun_q;
    assign late     = late_q;

endmodule

// File: tb/tb_p22_row_feeder.sv
// Scoreboard bench for p22_row_feeder: the stimulus process keeps an abstract
// model (pending/active records, divider countdown, arithmetic step and v0)
// and queues expected results; a negedge monitor pops and compares.
module tb_p22_row_feeder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_wall = '0;
    logic        wr_side = 1'b0;
    logic [10:0] wr_size = '0;
    logic [5:0]  wr_texu = '0;
    logic        row_start = 1'b0;
    logic        pix_adv = 1'b0;
    logic [1:0]  wall;
    logic        side;
    logic [10:0] size;
    logic [5:0]  texu;
    logic [5:0]  texv;
    logic        busy;
    logic        underrun;
    logic        late;

    p22_row_feeder dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_wall(wr_wall), .wr_side(wr_side), .wr_size(wr_size), .wr_texu(wr_texu),
        .row_start(row_start), .pix_adv(pix_adv), .wall(wall), .side(side),
        .size(size), .texu(texu), .texv(texv), .busy(busy), .underrun(underrun),
        .late(late)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wall; int side; int size; int texu; int under;
    } row_t;

    typedef struct {
        int wall; int side; int size; int texu; int texv;
        int busy; int under; int late; int rdy;
    } snap_t;

    row_t  q_row[$];
    int    q_div[$];
    snap_t q_snap[$];

    int n_chk = 0;
    int n_pass = 0;

    // Abstract model state
    bit m_pend_full;
    int mp_wall, mp_side, mp_size, mp_texu;
    int ma_wall, ma_side, ma_size, ma_texu;
    int m_under, m_late;
    int m_left;
    int m_step, m_next_step, m_acc;

    logic probe_req = 1'b0;
    logic rs_seen = 1'b0;
    logic rst_seen = 1'b0;
    logic busy_prev = 1'b0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    task automatic model_reset();
        m_pend_full = 0;
        mp_wall = 0; mp_side = 0; mp_size = 0; mp_texu = 0;
        ma_wall = 0; ma_side = 0; ma_size = 0; ma_texu = 0;
        m_under = 0; m_late = 0; m_left = 0;
        m_step = 0; m_next_step = 0; m_acc = 0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit fire;
        if (reset) begin
            model_reset();
            return;
        end
        fire = wr_valid && (!m_pend_full || row_start);
        if (row_start) begin
            if (m_pend_full) begin
                ma_wall = mp_wall; ma_side = mp_side; ma_size = mp_size; ma_texu = mp_texu;
                m_under = 0;
            end else begin
                ma_size = 0;
                m_under = 1;
            end
            m_left = 16;
            m_late = 0;
            m_acc  = 0;
            m_next_step = (ma_size == 0) ? 65535 : (32768 / ma_size);
            q_row.push_back('{ma_wall, ma_side, ma_size, ma_texu, m_under});
        end else if (m_left > 0) begin
            if (pix_adv) m_late = 1;
            m_left--;
            if (m_left == 0) begin
                m_step = m_next_step;
                m_acc  = (32768 - 320 * m_step) & 32'hFFFF;
                q_div.push_back(m_acc >> 10);
            end
        end else if (pix_adv) begin
            m_acc = (m_acc + m_step) & 32'hFFFF;
        end
        if (fire) begin
            mp_wall = int'(wr_wall); mp_side = int'(wr_side);
            mp_size = int'(wr_size); mp_texu = int'(wr_texu);
        end
        m_pend_full = fire || (m_pend_full && !row_start);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic probe();
        q_snap.push_back('{ma_wall, ma_side, ma_size, ma_texu, m_acc >> 10,
                           int'(m_left > 0), m_under, m_late,
                           int'(!m_pend_full || row_start)});
        probe_req = 1'b1;
        @(negedge clk);
        #1;
        probe_req = 1'b0;
    endtask

    task automatic write1(input int w, input int s, input int sz, input int tu);
        wr_wall = 2'(w); wr_side = 1'(s); wr_size = 11'(sz); wr_texu = 6'(tu);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic row_pulse();
        row_start = 1'b1;
        tick();
        row_start = 1'b0;
    endtask

    task automatic wait_div();
        for (int g = 0; g < 40 && m_left > 0; g++) tick();
    endtask

    task automatic pix_run(input int n);
        pix_adv = 1'b1;
        for (int i = 0; i < n; i++) tick();
        pix_adv = 1'b0;
    endtask

    // Monitor: compares whenever the DUT presents a row promotion, a divider
    // completion, or when the stimulus requests a snapshot.
    task automatic monitor_cycle();
        row_t  r;
        snap_t s;
        int    e;
        if (rs_seen) begin
            if (q_row.size() == 0) chk("row_queue_empty", 1, 0);
            else begin
                r = q_row.pop_front();
                chk("row_wall", wall, r.wall);
                chk("row_side", side, r.side);
                chk("row_size", size, r.size);
                chk("row_texu", texu, r.texu);
                chk("row_underrun", underrun, r.under);
                chk("row_busy", busy, 1);
                chk("row_texv", texv, 0);
                chk("row_late", late, 0);
            end
        end
        if (busy_prev && !busy && !rst_seen) begin
            if (q_div.size() == 0) chk("div_unexpected", 1, 0);
            else begin
                e = q_div.pop_front();
                chk("div_texv", texv, e);
            end
        end
        if (probe_req) begin
            if (q_snap.size() == 0) chk("snap_queue_empty", 1, 0);
            else begin
                s = q_snap.pop_front();
                chk("snap_wall", wall, s.wall);
                chk("snap_side", side, s.side);
                chk("snap_size", size, s.size);
                chk("snap_texu", texu, s.texu);
                chk("snap_texv", texv, s.texv);
                chk("snap_busy", busy, s.busy);
                chk("snap_underrun", underrun, s.under);
                chk("snap_late", late, s.late);
                chk("snap_wr_ready", wr_ready, s.rdy);
            end
        end
    endtask

    always @(posedge clk) begin
        rs_seen  <= row_start && !reset;
        rst_seen <= reset;
    end

    always @(negedge clk) busy_prev <= busy;

    always @(negedge clk) monitor_cycle();

    initial begin
        int sz;
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        probe();

        // Nominal wall: size 320
        write1(2, 1, 320, 17);
        probe();
        row_pulse();
        wait_div();
        probe();
        pix_run(639);
        probe();

        // size 1: texv alternates 32 / 0
        write1(1, 0, 1, 5);
        row_pulse();
        wait_div();
        probe();
        pix_run(1); probe();
        pix_run(1); probe();

        // size 0: step all ones, acc decrements
        write1(3, 1, 0, 40);
        row_pulse();
        wait_div();
        probe();
        pix_run(1100);
        probe();

        // Underrun: pending empty
        row_pulse();
        probe();
        wait_div();

        // Write in the same cycle as row_start with pending empty
        wr_wall = 2'd0; wr_side = 1'b1; wr_size = 11'd100; wr_texu = 6'd9;
        wr_valid = 1'b1; row_start = 1'b1;
        tick();
        wr_valid = 1'b0; row_start = 1'b0;
        probe();
        wait_div();
        row_pulse();
        wait_div();
        probe();

        // Back-to-back writes: second stalls until row_start
        write1(1, 1, 200, 33);
        wr_wall = 2'd2; wr_side = 1'b0; wr_size = 11'd7; wr_texu = 6'd60;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            probe();
        end
        row_start = 1'b1;
        tick();
        row_start = 1'b0; wr_valid = 1'b0;
        probe();
        wait_div();
        row_pulse();
        wait_div();
        pix_run(25);
        probe();

        // pix_adv while busy
        write1(0, 0, 50, 1);
        row_pulse();
        pix_run(3);
        probe();
        wait_div();
        probe();

        // Restart 5 cycles into the division
        write1(3, 0, 640, 12);
        row_pulse();
        for (int i = 0; i < 5; i++) tick();
        write1(2, 0, 3, 44);
        row_pulse();
        for (int g = 0; g < 40 && m_left > 1; g++) tick();
        probe();
        tick();
        probe();

        // Reset in the middle of a division
        write1(1, 1, 999, 2);
        row_pulse();
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        probe();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            row_start = ($urandom_range(0, 59) == 0);
            pix_adv   = ($urandom_range(0, 1) == 1);
            wr_valid  = ($urandom_range(0, 2) == 0);
            wr_wall   = 2'($urandom_range(0, 3));
            wr_side   = 1'($urandom_range(0, 1));
            sz        = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 2047);
            wr_size   = 11'(sz);
            wr_texu   = 6'($urandom_range(0, 63));
            tick();
            row_start = 1'b0; pix_adv = 1'b0; wr_valid = 1'b0;
            if ($urandom_range(0, 9) == 0) probe();
        end
        wait_div();
        tick();
        probe();
        tick();

        chk("row_queue_leftover", q_row.size(), 0);
        chk("div_queue_leftover", q_div.size(), 0);
        chk("snap_queue_leftover", q_snap.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/p22_row_feeder.md
Name: p22_row_feeder

Overview:
- Sits between the ray tracer and the per-row renderer.
- Accepts one trace result per row (wall, side, size, texu) from the tracer over a valid/ready handshake and holds it in a one-entry pending register.
- On each row start it promotes the pending entry to active. It then runs a sequential divider to derive a fixed-point texv step, and steps a texv accumulator once per pixel advance.
- Drives wall/side/size/texu/texv into the renderer.

Parameters:
- H_VIEW, 640, visible pixels per row; HALF_SIZE = H_VIEW/2.
- FRAC, 10, fractional bits of texv accumulator/step; accumulator width AW = 6+FRAC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- wr_valid  in  1  tracer has a row result.
- wr_ready  out  1  feeder can accept a result this cycle.
- wr_wall  in  2  wall texture ID.
- wr_side  in  1  light (1) / dark (0) side.
- wr_size  in  11  half-height of wall in pixels.
- wr_texu  in  6  texture u coordinate.
- row_start  in  1  one-cycle pulse at start of hblank preceding a row.
- pix_adv  in  1  one-cycle pulse each time hpos increments in the visible area.
- wall  out  2  active wall ID.
- side  out  1  active side.
- size  out  11  active size.
- texu  out  6  active texu.
- texv  out  6  current texv = acc[AW-1:FRAC].
- busy  out  1  divider running.
- underrun  out  1  row_start found pending empty; held until next row_start.
- late  out  1  pix_adv arrived while busy; sticky until next row_start.

Behaviour:
- Reset values:
  - wall/side/size/texu/texv = 0.
  - busy = 0, underrun = 0, late = 0.
  - pending empty, so wr_ready = 1.
  - acc = 0, step = 0.
- Pending register:
  - wr_ready = !pend_full | row_start.
  - Transfer occurs when wr_valid & wr_ready; it sets pend_full.
- row_start, cycle N:
  - If pend_full: at N+1 the active fields take the pending values and pend_full clears, unless a write also occurs in cycle N, which refills it.
  - If pend_full = 0: the active fields keep their previous values; size is forced to 0; underrun = 1 at N+1.
  - There is no bypass: a write in the same cycle as row_start with pending empty lands in pending only. It does not become active, and underrun is still set.
  - late clears; acc clears (texv = 0); busy = 1 at N+1.
- Divider:
  - Restoring, one quotient bit per cycle, 16 cycles.
  - Computes step = floor(2^(5+FRAC) / size); 2^15 for FRAC = 10.
  - size = 0: divider is skipped in effect, and step = all ones (16'hFFFF).
  - On the final cycle: busy drops (busy high cycles N+1..N+16), and at N+17 acc loads v0 = (2^(5+FRAC) − HALF_SIZE·step) mod 2^AW.
  - HALF_SIZE·step is a constant multiply.
- pix_adv:
  - When !busy: acc <= acc + step, wrapping mod 2^AW; texv follows next cycle.
  - When busy: ignored, and late <= 1.
- row_start while busy (mid-operation): the divider aborts and restarts with the new active size. The standard row_start handling above applies.
- Reset asserted mid-division: returns to reset state next cycle.
- All outputs are registered; no combinational path from wr_* to outputs.

Test Plan:
- Reset, write {wall=2, side=1, size=320, texu=17}, then row_start → next cycle wall=2, side=1, size=320, texu=17, busy=1. After 16 cycles busy=0, step=102, acc=128, texv=0. After 639 pix_adv, acc=65306, texv=63.
- size=1 → step=32768, v0=32768, texv=32. Alternates 0/32 on successive pix_adv.
- size=0 → step=16'hFFFF. Each pix_adv decrements acc by 1 mod 2^16; wall/side/texu still updated.
- row_start with pending empty → underrun=1, size=0, previous wall/texu held.
- Write in same cycle as row_start with pending empty → write lands in pending (pend_full=1), underrun=1. Next row_start promotes it and clears underrun.
- Back-to-back writes with no row_start → second write stalls (wr_ready=0) until row_start, then is accepted that same cycle.
- pix_adv during busy → late=1, acc unchanged.
- row_start again 5 cycles into busy → divider restarts; busy stays high for 16 more cycles.
